uart_tx: RTL and testbench



---
 rtl/uart_tx_if.sv | 23 ++
 rtl/uart_tx.sv | 138 +++++++++++++
 tb/tb_uart_tx.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Bus bundle for the UART transmitter: control, holding-register write port and status.
interface uart_tx_if #(
    parameter int BRG_W = 16
);
    logic             TXEN;
    logic [BRG_W-1:0] BRG;
    logic             wr_en;
    logic [7:0]       din;
    logic             UTXBRK;
    logic             UxTX;
    logic             UxTXIF;
    logic             TRMT;

    modport master (
        output TXEN, BRG, wr_en, din, UTXBRK,
        input  UxTX, UxTXIF, TRMT
    );

    modport slave (
        input  TXEN, BRG, wr_en, din, UTXBRK,
        output UxTX, UxTXIF, TRMT
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 frames with a one-entry holding register and sync-break generation.
//
// state | meaning
// IDLE  | line high, waiting for the holding register to fill
// START | start bit (low)
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); may chain straight into the next frame
// BREAK | thirteen low bit periods ahead of an auto-baud sync character
module uart_tx #(
    parameter int BRG_W = 16
) (
    input logic     clk,
    input logic     rst,
    uart_tx_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t           state_q, state_d;
    logic             full_q, full_d;
    logic [7:0]       hold_q, hold_d;
    logic [7:0]       shift_q, shift_d;
    logic [BRG_W-1:0] bcnt_q, bcnt_d;
    logic [BRG_W-1:0] brg_q, brg_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic             tx_q, tx_d;

    logic tick;
    logic xfer;
    logic wr_ok;

    // The divisor in use is latched at transfer and at each wrap, so BRG edits land on a wrap.
    assign tick  = (state_q != IDLE) && (bcnt_q == brg_q);
    assign xfer  = bus.TXEN && full_q && ((state_q == IDLE) || ((state_q == STOP) && tick));
    assign wr_ok = bus.wr_en && bus.TXEN && (!full_q || xfer);

    // Next-state, holding register, counters and the next value of the serial line.
    always_comb begin
        state_d  = state_q;
        full_d   = full_q;
        hold_d   = hold_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        bcnt_d   = ((state_q == IDLE) || tick) ? '0 : bcnt_q + 1'b1;
        brg_d    = tick ? bus.BRG : brg_q;

        if (wr_ok) begin
            full_d = 1'b1;
            hold_d = bus.din;
        end else if (xfer) begin
            full_d = 1'b0;
        end

        case (state_q)
            IDLE: ;
            START: begin
                if (tick) begin
                    state_d  = DATA;
                    bitcnt_d = 4'd0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d  = {1'b0, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd7) begin
                        state_d = STOP;
                    end
                end
            end
            BREAK: begin
                if (tick) begin
                    if (bitcnt_q == 4'd12) begin
                        state_d  = STOP;
                        bitcnt_d = 4'd0;
                    end else begin
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A transfer restarts the bit timing so the first bit is always a full period.
        if (xfer) begin
            state_d  = bus.UTXBRK ? BREAK : START;
            shift_d  = hold_q;
            bitcnt_d = 4'd0;
            bcnt_d   = '0;
            brg_d    = bus.BRG;
        end

        if (!bus.TXEN) begin
            state_d  = IDLE;
            full_d   = 1'b0;
            bitcnt_d = 4'd0;
            bcnt_d   = '0;
        end

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            BREAK:   tx_d = 1'b0;
            default: tx_d = 1'b1;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            full_q   <= 1'b0;
            hold_q   <= 8'h00;
            shift_q  <= 8'h00;
            bcnt_q   <= '0;
            brg_q    <= '0;
            bitcnt_q <= 4'd0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            full_q   <= full_d;
            hold_q   <= hold_d;
            shift_q  <= shift_d;
            bcnt_q   <= bcnt_d;
            brg_q    <= brg_d;
            bitcnt_q <= bitcnt_d;
            tx_q     <= tx_d;
        end
    end

    assign bus.UxTX   = tx_q;
    assign bus.UxTXIF = !full_q;
    assign bus.TRMT   = (state_q == IDLE);
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame shape, chaining, overrun, break, abort and async reset.
module tb_uart_tx;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    uart_tx_if #(.BRG_W(16)) bus ();

    uart_tx #(.BRG_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Samples one whole 8N1 frame cycle by cycle, starting at its first start-bit cycle.
    // Optionally issues one write strobe at cycle inj_idx of the frame.
    task automatic check_frame(input logic [7:0] data, input int bp,
                               input int inj_idx, input logic [7:0] inj_data);
        logic [9:0] bits;
        bits = {1'b1, data, 1'b0};
        for (int idx = 0; idx < 10 * bp; idx++) begin
            if (idx == inj_idx) begin
                bus.wr_en = 1'b1;
                bus.din   = inj_data;
            end
            chk($sformatf("frame %h bit %0d", data, idx / bp), bus.UxTX, bits[idx / bp]);
            chk($sformatf("frame %h TRMT", data), bus.TRMT, 1'b0);
            step();
            bus.wr_en = 1'b0;
        end
    endtask

    task automatic write(input logic [7:0] d);
        bus.wr_en = 1'b1;
        bus.din   = d;
        step();
        bus.wr_en = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        bus.TXEN   = 1'b0;
        bus.BRG    = 16'd3;
        bus.wr_en  = 1'b0;
        bus.din    = 8'h00;
        bus.UTXBRK = 1'b0;
        #3;
        chk("reset UxTX", bus.UxTX, 1'b1);
        chk("reset UxTXIF", bus.UxTXIF, 1'b1);
        chk("reset TRMT", bus.TRMT, 1'b1);
        step();
        rst      = 1'b0;
        bus.TXEN = 1'b1;
        step();

        // Single frame 0xA5 at BRG=3
        write(8'hA5);
        chk("single full after write", bus.UxTXIF, 1'b0);
        chk("single line idle after write", bus.UxTX, 1'b1);
        chk("single TRMT after write", bus.TRMT, 1'b1);
        step();
        chk("single UxTXIF after transfer", bus.UxTXIF, 1'b1);
        check_frame(8'hA5, 4, -1, 8'h00);
        chk("single TRMT end", bus.TRMT, 1'b1);
        chk("single line end", bus.UxTX, 1'b1);
        step();

        // Back-to-back: 0xFF written while 0x00 is in DATA
        write(8'h00);
        step();
        check_frame(8'h00, 4, 10, 8'hFF);
        check_frame(8'hFF, 4, -1, 8'h00);
        chk("b2b TRMT end", bus.TRMT, 1'b1);
        step();

        // Overrun: simultaneous write+transfer keeps 0x22, later 0x33 dropped
        write(8'h11);
        write(8'h22);
        chk("simul write keeps full", bus.UxTXIF, 1'b0);
        check_frame(8'h11, 4, 8, 8'h33);
        check_frame(8'h22, 4, -1, 8'h00);
        chk("overrun TRMT end", bus.TRMT, 1'b1);
        chk("overrun empty end", bus.UxTXIF, 1'b1);
        step();

        // Break + sync at BRG=1
        bus.BRG    = 16'd1;
        bus.UTXBRK = 1'b1;
        write(8'h00);
        step();
        bus.UTXBRK = 1'b0;
        for (int i = 0; i < 26; i++) begin
            chk($sformatf("break low %0d", i), bus.UxTX, 1'b0);
            chk("break TRMT", bus.TRMT, 1'b0);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("break stop %0d", i), bus.UxTX, 1'b1);
            step();
        end
        chk("break TRMT end", bus.TRMT, 1'b1);
        write(8'h55);
        step();
        check_frame(8'h55, 2, -1, 8'h00);
        chk("sync TRMT end", bus.TRMT, 1'b1);
        step();

        // Abort mid-DATA with a byte held; write during TXEN=0 ignored
        bus.BRG = 16'd3;
        write(8'hC3);
        step();
        for (int i = 0; i < 6; i++) step();
        write(8'h3C);
        chk("abort held full", bus.UxTXIF, 1'b0);
        step();
        chk("abort in frame TRMT", bus.TRMT, 1'b0);
        bus.TXEN  = 1'b0;
        bus.wr_en = 1'b1;
        bus.din   = 8'h99;
        step();
        bus.wr_en = 1'b0;
        bus.TXEN  = 1'b1;
        chk("abort UxTX", bus.UxTX, 1'b1);
        chk("abort TRMT", bus.TRMT, 1'b1);
        chk("abort UxTXIF", bus.UxTXIF, 1'b1);
        for (int i = 0; i < 50; i++) begin
            chk("abort stays idle", bus.UxTX, 1'b1);
            chk("abort TRMT idle", bus.TRMT, 1'b1);
            step();
        end

        // Async reset during start bit with a byte held
        write(8'h0F);
        write(8'hF0);
        chk("areset start bit low", bus.UxTX, 1'b0);
        chk("areset held full", bus.UxTXIF, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("areset UxTX", bus.UxTX, 1'b1);
        chk("areset UxTXIF", bus.UxTXIF, 1'b1);
        chk("areset TRMT", bus.TRMT, 1'b1);
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 20; i++) begin
            chk("post reset idle", bus.UxTX, 1'b1);
            chk("post reset TRMT", bus.TRMT, 1'b1);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
